alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor of the 8-bit combinational ALU: same opcode map
//  plus shifts, add-with-carry and optional multiply. Valid/ready on input and output,
//  one-cycle latency for single-cycle ops, persistent carry flag across operations.
//  Sits between operand/opcode source and result consumer in the datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand/opcode presented
//  in_ready   out  1      block can accept; transfer when in_valid && in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount for SHL/SHR)
//  s          in   4      opcode select
//  out_valid  out  1      r/c/v/z valid
//  out_ready  in   1      consumer takes result when out_valid && out_ready
//  r          out  WIDTH  result
//  c          out  1      carry/borrow/shift-out
//  v          out  1      signed overflow
//  z          out  1      r == 0
// BEHAVIOUR
//  - Opcodes: 1110 AND, 1101 OR, 1100 NOT a, 1011 XOR, 1010 ADD a+b, 1001 SUB a-b,
//    1000 PASS a, 0111 ZTEST r=(a==0), 0110 SHL a<<b, 0101 SHR a>>b (logical),
//    0100 ADC a+b+cf, 0011 MUL (optional); all others: r=0, c=v=0.
//  - ADD/ADC: c = carry out of bit WIDTH-1; v = signed overflow. SUB: c = borrow (a<b
//    unsigned); v = signed overflow. SHL/SHR: c = last bit shifted out, 0 if b==0;
//    b>=WIDTH -> r=0, c=0. All other ops c=v=0. z always = (r==0).
//  - cf (internal carry flag) updated with c on ADD, SUB, ADC accept only; else held.
//  - FSM states: IDLE (no result held), FULL (out_valid=1), MUL (iterating).
//    IDLE: accept -> FULL (or MUL if s==0011 and MUL enabled).
//    FULL: out_ready=1 with simultaneous accept -> FULL with new result (throughput 1/clk);
//      out_ready=1, no accept -> IDLE; out_ready=0 -> hold r/c/v/z stable.
//    MUL: shift-add, one bit per clk, WIDTH clks, then FULL.
//  - in_ready = (state!=MUL) && (!out_valid || out_ready).
//  - Latency: single-cycle ops out_valid the clk after accept; MUL out_valid exactly
//    WIDTH clks after accept.
//  - Operands and opcode captured at accept; later changes on a/b/s are ignored.
//  - Reset (any time, incl. mid-MUL): state IDLE, out_valid=0, r=0, c=v=0, z=0, cf=0,
//    partial product discarded; in_ready reads 1 after reset deasserts.
//  - Arithmetic on WIDTH+1 bits internally; r truncated to WIDTH.
// CONFIGURATION
//  - ALU_PIPE_MUL_EN defined: opcode 0011 = unsigned a*b, r = low WIDTH bits,
//    c = (high WIDTH bits != 0), v=0, multi-cycle via MUL state.
//  - Undefined: no MUL state or multiplier logic; 0011 treated as undefined opcode
//    (r=0, c=v=0, z=1, single-cycle).
// TESTING  (WIDTH=8, out_ready=1 unless stated)
//  - ADD 200+100 -> r=0x2C c=1 v=0 z=0, out_valid 1 clk after accept; then ADC
//    0x01+0x00 -> r=0x02 (cf=1 consumed), c=0.
//  - SUB 1-1 -> r=0x00 c=0 v=0 z=1; SUB 0x00-0x01 -> r=0xFF c=1; SUB 0x80-0x01 ->
//    r=0x7F v=1.
//  - ZTEST a=0 -> r=0x01; a=0xFF -> r=0x00 z=1; NOT 0x01 -> r=0xFE; SHL 0x81 by 1 ->
//    r=0x02 c=1; SHR 0x01 by 9 -> r=0x00 c=0.
//  - Backpressure: out_ready=0 after AND 0x01&0x01 -> r=0x01 held, in_ready=0 for 5 clks
//    while a/b/s toggle; raise out_ready with queued XOR -> result consumed and XOR
//    accepted same clk, XOR result next clk.
//  - ALU_PIPE_MUL_EN: MUL 15*17 -> r=0xFF c=0 after exactly 8 clks, in_ready=0 during;
//    16*16 -> r=0x00 c=1 z=1; rst_n low at clk 4 of MUL -> out_valid=0, cf=0, no result.
//  - Macro undefined: s=0011 a=5 b=7 -> r=0x00 z=1 c=0, out_valid 1 clk after accept.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered valid/ready ALU with a persistent carry flag.
// Define ALU_PIPE_MUL_EN to enable opcode 0011 as a multi-cycle shift-add unsigned multiply.
// When the macro is undefined, 0011 is handled like any other undefined opcode.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam logic [3:0] OP_AND   = 4'b1110;
    localparam logic [3:0] OP_OR    = 4'b1101;
    localparam logic [3:0] OP_NOT   = 4'b1100;
    localparam logic [3:0] OP_XOR   = 4'b1011;
    localparam logic [3:0] OP_ADD   = 4'b1010;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_PASS  = 4'b1000;
    localparam logic [3:0] OP_ZTEST = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0101;
    localparam logic [3:0] OP_ADC   = 4'b0100;
    localparam logic [WIDTH-1:0] W_L = WIDTH[WIDTH-1:0];

`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, FULL, MUL} state_t;
`else
    typedef enum logic [0:0] {IDLE, FULL} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d, v_q, v_d, z_q, z_d, cf_q, cf_d;
    logic [WIDTH:0]   sum, diff, shl, shr;
    logic             big, accept, arith;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v;

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_nx;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`endif

    assign out_valid = state_q == FULL;
`ifdef ALU_PIPE_MUL_EN
    assign in_ready = (state_q != MUL) && (!out_valid || out_ready);
`else
    assign in_ready = !out_valid || out_ready;
`endif
    assign accept = in_valid && in_ready;
    assign arith  = (s == OP_ADD) || (s == OP_SUB) || (s == OP_ADC);
    assign r = r_q;
    assign c = c_q;
    assign v = v_q;
    assign z = z_q;

    // Single-cycle ALU on the live operands; the result is only used on accept.
    // Arithmetic is done one bit wider so bit WIDTH carries the carry/borrow/shift-out.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (s == OP_ADC) & cf_q};
        diff  = {1'b0, a} - {1'b0, b};
        shl   = {1'b0, a} << b;
        shr   = {a, 1'b0} >> b;
        big   = b >= W_L;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (s)
            OP_AND:   alu_r = a & b;
            OP_OR:    alu_r = a | b;
            OP_NOT:   alu_r = ~a;
            OP_XOR:   alu_r = a ^ b;
            OP_ADD, OP_ADC: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_PASS:  alu_r = a;
            OP_ZTEST: alu_r = {{(WIDTH-1){1'b0}}, a == '0};
            OP_SHL: begin
                alu_r = big ? '0 : shl[WIDTH-1:0];
                alu_c = !big && shl[WIDTH];
            end
            OP_SHR: begin
                alu_r = big ? '0 : shr[WIDTH:1];
                alu_c = !big && shr[0];
            end
            default: ;
        endcase
    end

    // Next-state for the handshake FSM, the result registers, the carry flag and the multiplier.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        cf_d    = cf_q;
`ifdef ALU_PIPE_MUL_EN
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        prod_nx  = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (s == OP_MUL) begin
                state_d  = MUL;
                prod_d   = '0;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                cnt_d    = '0;
            end else
`endif
            begin
                state_d = FULL;
                r_d     = alu_r;
                c_d     = alu_c;
                v_d     = alu_v;
                z_d     = alu_r == '0;
                cf_d    = arith ? alu_c : cf_q;
            end
        end else if (state_q == FULL && out_ready) begin
            state_d = IDLE;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (state_q == MUL) begin
            prod_d   = prod_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = FULL;
                r_d     = prod_nx[WIDTH-1:0];
                c_d     = |prod_nx[2*WIDTH-1:WIDTH];
                v_d     = 1'b0;
                z_d     = prod_nx[WIDTH-1:0] == '0;
            end
        end
`endif
    end

    // State and result registers; reset discards any held result or partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            cf_q    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            cf_q    <= cf_d;
`ifdef ALU_PIPE_MUL_EN
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe at WIDTH=8
module tb_alu_pipe;

    localparam logic [3:0] OP_AND   = 4'b1110;
    localparam logic [3:0] OP_OR    = 4'b1101;
    localparam logic [3:0] OP_NOT   = 4'b1100;
    localparam logic [3:0] OP_XOR   = 4'b1011;
    localparam logic [3:0] OP_ADD   = 4'b1010;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_PASS  = 4'b1000;
    localparam logic [3:0] OP_ZTEST = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0101;
    localparam logic [3:0] OP_ADC   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] s = '0;
    logic       in_ready, out_valid, c, v, z;
    logic [7:0] r;
    int         checks = 0;
    int         errors = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .c(c), .v(v), .z(z)
    );

    always #5 clk = ~clk;

    // Present one operation, wait (bounded) for in_ready, and step past the accepting edge.
    task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts);
        int n = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        s = ts;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drive_accept: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, r, c, v, z} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: ov/r/cvz=%b/%h/%b want 0/00/000", out_valid, r, {c, v, z});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_adc;
        drive(8'd200, 8'd100, OP_ADD);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h2C, 3'b100}) begin
            errors++;
            $display("FAIL add_200_100: ov/r/cvz=%b/%h/%b want 1/2c/100", out_valid, r, {c, v, z});
        end
        drive(8'h01, 8'h00, OP_ADC);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h02, 3'b000}) begin
            errors++;
            $display("FAIL adc_cf1: ov/r/cvz=%b/%h/%b want 1/02/000", out_valid, r, {c, v, z});
        end
    endtask

    task automatic test_sub;
        drive(8'h01, 8'h01, OP_SUB);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL sub_1_1: ov/r/cvz=%b/%h/%b want 1/00/001", out_valid, r, {c, v, z});
        end
        drive(8'h00, 8'h01, OP_SUB);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'hFF, 3'b100}) begin
            errors++;
            $display("FAIL sub_0_1: ov/r/cvz=%b/%h/%b want 1/ff/100", out_valid, r, {c, v, z});
        end
        drive(8'h80, 8'h01, OP_SUB);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h7F, 3'b010}) begin
            errors++;
            $display("FAIL sub_80_1: ov/r/cvz=%b/%h/%b want 1/7f/010", out_valid, r, {c, v, z});
        end
    endtask

    task automatic test_logic_shift;
        logic [7:0] va [10];
        logic [7:0] vb [10];
        logic [3:0] vs [10];
        logic [11:0] exp_rcvz [10];
        va = '{8'h00, 8'hFF, 8'h01, 8'h81, 8'h01, 8'h03, 8'h01, 8'h81, 8'h0F, 8'h55};
        vb = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h09, 8'h01, 8'h08, 8'h00, 8'hF0, 8'hAA};
        vs = '{OP_ZTEST, OP_ZTEST, OP_NOT, OP_SHL, OP_SHR, OP_SHR, OP_SHL, OP_SHL, OP_OR, 4'b0000};
        exp_rcvz = '{{8'h01, 4'b0000}, {8'h00, 4'b0001}, {8'hFE, 4'b0000}, {8'h02, 4'b0100},
                     {8'h00, 4'b0001}, {8'h01, 4'b0100}, {8'h00, 4'b0001}, {8'h81, 4'b0000},
                     {8'hFF, 4'b0000}, {8'h00, 4'b0001}};
        for (int i = 0; i < 10; i++) begin
            drive(va[i], vb[i], vs[i]);
            checks++;
            if ({out_valid, r, 1'b0, c, v, z} !== {1'b1, exp_rcvz[i]}) begin
                errors++;
                $display("FAIL logic_shift[%0d] s=%b a=%h b=%h: ov/r/cvz=%b/%h/%b want 1/%h/%b",
                         i, vs[i], va[i], vb[i], out_valid, r, {c, v, z}, exp_rcvz[i][11:4], exp_rcvz[i][2:0]);
            end
        end
    endtask

    task automatic test_cf_hold;
        drive(8'hFF, 8'h01, OP_ADD);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h00, 3'b101}) begin
            errors++;
            $display("FAIL add_ff_1: ov/r/cvz=%b/%h/%b want 1/00/101", out_valid, r, {c, v, z});
        end
        drive(8'h55, 8'h00, OP_PASS);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h55, 3'b000}) begin
            errors++;
            $display("FAIL pass_55: ov/r/cvz=%b/%h/%b want 1/55/000", out_valid, r, {c, v, z});
        end
        drive(8'h00, 8'h00, OP_ADC);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h01, 3'b000}) begin
            errors++;
            $display("FAIL adc_cf_held: ov/r/cvz=%b/%h/%b want 1/01/000", out_valid, r, {c, v, z});
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(8'h01, 8'h01, OP_AND);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37 + 5);
            b = 8'(i * 11 + 3);
            s = (i % 2 == 0) ? OP_SUB : OP_OR;
            #1;
            checks++;
            if ({in_ready, out_valid, r, c, v, z} !== {2'b01, 8'h01, 3'b000}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: in_ready/ov/r/cvz=%b/%b/%h/%b want 0/1/01/000",
                         i, in_ready, out_valid, r, {c, v, z});
            end
            @(posedge clk); #1;
        end
        a = 8'h0F;
        b = 8'h3C;
        s = OP_XOR;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h33, 3'b000}) begin
            errors++;
            $display("FAIL backpressure_xor: ov/r/cvz=%b/%h/%b want 1/33/000", out_valid, r, {c, v, z});
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'h01; b = 8'h02; s = OP_ADD;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h03, 3'b000}) begin
            errors++;
            $display("FAIL b2b_add: ov/r/cvz=%b/%h/%b want 1/03/000", out_valid, r, {c, v, z});
        end
        a = 8'h7F; b = 8'h01; s = OP_ADD;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h80, 3'b010}) begin
            errors++;
            $display("FAIL b2b_ovf: ov/r/cvz=%b/%h/%b want 1/80/010", out_valid, r, {c, v, z});
        end
        a = 8'hF0; b = 8'h3C; s = OP_AND;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h30, 3'b000}) begin
            errors++;
            $display("FAIL b2b_and: ov/r/cvz=%b/%h/%b want 1/30/000", out_valid, r, {c, v, z});
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul;
        logic [7:0] ma [2];
        logic [7:0] mb [2];
        logic [11:0] exp_rcvz [2];
        logic seen;
        ma = '{8'd15, 8'd16};
        mb = '{8'd17, 8'd16};
        exp_rcvz = '{{8'hFF, 4'b0000}, {8'h00, 4'b0101}};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(ma[k], mb[k], OP_MUL);
            a = 8'h00; b = 8'h00; s = OP_AND;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({out_valid, in_ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL mul_busy[%0d][%0d]: ov/in_ready=%b/%b want 0/0", k, i, out_valid, in_ready);
                end
                @(posedge clk); #1;
            end
            checks++;
            if ({out_valid, r, 1'b0, c, v, z} !== {1'b1, exp_rcvz[k]}) begin
                errors++;
                $display("FAIL mul_result[%0d]: ov/r/cvz=%b/%h/%b want 1/%h/%b",
                         k, out_valid, r, {c, v, z}, exp_rcvz[k][11:4], exp_rcvz[k][2:0]);
            end
        end
        drive(8'hFF, 8'h01, OP_ADD);
        drive(8'd15, 8'd17, OP_MUL);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, r, c, v, z} !== 12'h000) begin
            errors++;
            $display("FAIL mul_reset: ov/r/cvz=%b/%h/%b want 0/00/000", out_valid, r, {c, v, z});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mul_reset_no_result: out_valid seen=%b want 0", seen);
        end
        drive(8'h00, 8'h00, OP_ADC);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL mul_reset_cf: ov/r/cvz=%b/%h/%b want 1/00/001", out_valid, r, {c, v, z});
        end
    endtask
`else
    task automatic test_mul_undef;
        drive(8'd5, 8'd7, OP_MUL);
        checks++;
        if ({out_valid, r, c, v, z} !== {1'b1, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL mul_undef: ov/r/cvz=%b/%h/%b want 1/00/001", out_valid, r, {c, v, z});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add_adc();
        test_sub();
        test_logic_shift();
        test_cf_hold();
        test_backpressure();
        test_back_to_back();
`ifdef ALU_PIPE_MUL_EN
        test_mul();
`else
        test_mul_undef();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
